// File: rtl/uart_core.sv
// Parametrised single-clock UART with independent TX and RX state machines.
// Both sides run from baud/oversample tick counters derived from clk.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | line idle; TX waits for a handshake, RX waits for a falling edge
//   ST_START  | start bit (TX drives 0, RX confirms low at mid-bit)
//   ST_DATA   | DATA_BITS data bits, LSB first
//   ST_PARITY | optional parity bit (PARITY != 0 only)
//   ST_STOP   | stop bit(s); TX holds 1, RX checks the first one only
`timescale 1ns/1ps
module uart_core #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rxEn,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 rxBusy,
    output logic                 rxParityErr,
    output logic                 rxFrameErr,
    output logic                 tx,
    input  logic                 txEn,
    input  logic                 txValid,
    output logic                 txReady,
    input  logic [DATA_BITS-1:0] txData,
    output logic                 txBusy,
    output logic                 txDone
);

    localparam int TX_DIV_RAW = CLOCK_RATE / BAUD_RATE;
    localparam int TX_DIV     = (TX_DIV_RAW < 1) ? 1 : TX_DIV_RAW;
    localparam int RX_DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int RX_DIV     = (RX_DIV_RAW < 1) ? 1 : RX_DIV_RAW;
    localparam int TX_CW      = $clog2(TX_DIV + 1);
    localparam int RX_DW      = $clog2(RX_DIV + 1);
    localparam int OS_W       = $clog2(OVERSAMPLE + 1);
    localparam int BIT_W      = $clog2(DATA_BITS + 1);

    localparam logic [TX_CW-1:0] TX_RELOAD = TX_CW'(TX_DIV - 1);
    localparam logic [RX_DW-1:0] RX_RELOAD = RX_DW'(RX_DIV - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_RELOAD = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY == 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // ---------------- transmitter ----------------
    logic [2:0]           txState;
    logic [TX_CW-1:0]     txCnt;
    logic [BIT_W-1:0]     txBits;
    logic [DATA_BITS-1:0] txShift;
    logic                 txPar;
    logic                 txLine;
    logic                 txArmed;
    logic                 txAccept;
    logic                 txBitEnd;

    // txArmed keeps txReady low while rst is asserted even though the FSM sits in IDLE
    assign txReady  = txEn && txArmed && (txState == ST_IDLE);
    assign txAccept = txValid && txReady;
    assign txBitEnd = (txCnt == '0);
    assign txBusy   = (txState != ST_IDLE);
    assign txDone   = (txState == ST_STOP) && txBitEnd && (txBits == '0);
    assign tx       = txLine;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txState <= ST_IDLE;
            txCnt   <= '0;
            txBits  <= '0;
            txShift <= '0;
            txPar   <= 1'b0;
            txLine  <= 1'b1;
            txArmed <= 1'b0;
        end else begin
            txArmed <= 1'b1;
            if (txState == ST_IDLE) begin
                if (txAccept) begin
                    txState <= ST_START;
                    txCnt   <= TX_RELOAD;
                    txShift <= txData;
                    txPar   <= (^txData) ^ ODD;
                    txLine  <= 1'b0;
                end
            end else if (!txBitEnd) begin
                txCnt <= txCnt - 1'b1;
            end else begin
                txCnt <= TX_RELOAD;
                case (txState)
                    ST_START: begin
                        txState <= ST_DATA;
                        txLine  <= txShift[0];
                        txBits  <= DATA_LAST;
                    end
                    ST_DATA: begin
                        if (txBits != '0) begin
                            txShift <= txShift >> 1;
                            txLine  <= txShift[1];
                            txBits  <= txBits - 1'b1;
                        end else if (PARITY != 0) begin
                            txState <= ST_PARITY;
                            txLine  <= txPar;
                        end else begin
                            txState <= ST_STOP;
                            txLine  <= 1'b1;
                            txBits  <= STOP_LAST;
                        end
                    end
                    ST_PARITY: begin
                        txState <= ST_STOP;
                        txLine  <= 1'b1;
                        txBits  <= STOP_LAST;
                    end
                    ST_STOP: begin
                        if (txBits != '0) txBits <= txBits - 1'b1;
                        else              txState <= ST_IDLE;
                    end
                    default: txState <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    logic                 rxMeta;
    logic                 rxSync;
    logic                 rxPrev;
    logic [2:0]           rxState;
    logic [RX_DW-1:0]     rxDiv;
    logic [OS_W-1:0]      rxOs;
    logic [BIT_W-1:0]     rxBits;
    logic [DATA_BITS-1:0] rxShift;
    logic                 rxParBad;
    logic                 rxTick;
    logic                 rxSample;
    logic                 rxFall;

    assign rxTick   = (rxDiv == '0);
    assign rxSample = rxTick && (rxOs == '0);
    assign rxFall   = rxPrev && !rxSync;
    assign rxBusy   = (rxState != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta      <= 1'b1;
            rxSync      <= 1'b1;
            rxPrev      <= 1'b1;
            rxState     <= ST_IDLE;
            rxDiv       <= '0;
            rxOs        <= '0;
            rxBits      <= '0;
            rxShift     <= '0;
            rxParBad    <= 1'b0;
            rxData      <= '0;
            rxValid     <= 1'b0;
            rxParityErr <= 1'b0;
            rxFrameErr  <= 1'b0;
        end else begin
            rxMeta  <= rx;
            rxSync  <= rxMeta;
            rxPrev  <= rxSync;
            rxValid <= 1'b0;
            if (rxState == ST_IDLE) begin
                // first sample lands half a bit after the edge, then every full bit
                if (rxEn && rxFall) begin
                    rxState <= ST_START;
                    rxDiv   <= RX_RELOAD;
                    rxOs    <= OS_HALF;
                end
            end else if (!rxEn) begin
                rxState <= ST_IDLE;
            end else begin
                rxDiv <= rxTick ? RX_RELOAD : rxDiv - 1'b1;
                if (rxTick) rxOs <= (rxOs == '0) ? OS_RELOAD : rxOs - 1'b1;
                if (rxSample) begin
                    case (rxState)
                        ST_START: begin
                            if (rxSync) begin
                                rxState <= ST_IDLE;
                            end else begin
                                rxState <= ST_DATA;
                                rxBits  <= DATA_LAST;
                            end
                        end
                        ST_DATA: begin
                            rxShift <= {rxSync, rxShift[DATA_BITS-1:1]};
                            if (rxBits == '0) rxState <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            else              rxBits  <= rxBits - 1'b1;
                        end
                        ST_PARITY: begin
                            rxParBad <= rxSync ^ (^rxShift) ^ ODD;
                            rxState  <= ST_STOP;
                        end
                        ST_STOP: begin
                            rxState     <= ST_IDLE;
                            rxValid     <= 1'b1;
                            rxData      <= rxShift;
                            rxParityErr <= (PARITY != 0) && rxParBad;
                            rxFrameErr  <= !rxSync;
                        end
                        default: rxState <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: 8N1 TX/RX, even-parity 2-stop loopback, odd-parity RX,
// framing error, glitch rejection, rxEn abort and asynchronous reset mid-frame.
`timescale 1ns/1ps
module tb_uart_core;

    localparam int CR  = 1600;
    localparam int BR  = 100;
    localparam int OS  = 16;
    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: 8N1
    logic       rxA = 1'b1, rxEnA = 1'b1, txEnA = 1'b1, txValidA = 1'b0;
    logic [7:0] txDataA = 8'h00;
    logic [7:0] rxDataA;
    logic       rxValidA, rxBusyA, rxParA, rxFrameA, txA, txReadyA, txBusyA, txDoneA;

    // instance B: even parity, 2 stop bits, tx looped to rx
    logic       rxEnB = 1'b1, txEnB = 1'b1, txValidB = 1'b0;
    logic [7:0] txDataB = 8'h00;
    logic [7:0] rxDataB;
    logic       rxValidB, rxBusyB, rxParB, rxFrameB, txB, txReadyB, txBusyB, txDoneB;

    // instance C: odd parity, receive only
    logic       rxC = 1'b1, rxEnC = 1'b1, txEnC = 1'b0, txValidC = 1'b0;
    logic [7:0] txDataC = 8'h00;
    logic [7:0] rxDataC;
    logic       rxValidC, rxBusyC, rxParC, rxFrameC, txC, txReadyC, txBusyC, txDoneC;

    uart_core #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) uDutA (
        .clk(clk), .rst(rst), .rx(rxA), .rxEn(rxEnA), .rxData(rxDataA), .rxValid(rxValidA),
        .rxBusy(rxBusyA), .rxParityErr(rxParA), .rxFrameErr(rxFrameA), .tx(txA), .txEn(txEnA),
        .txValid(txValidA), .txReady(txReadyA), .txData(txDataA), .txBusy(txBusyA), .txDone(txDoneA));

    uart_core #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(OS)) uDutB (
        .clk(clk), .rst(rst), .rx(txB), .rxEn(rxEnB), .rxData(rxDataB), .rxValid(rxValidB),
        .rxBusy(rxBusyB), .rxParityErr(rxParB), .rxFrameErr(rxFrameB), .tx(txB), .txEn(txEnB),
        .txValid(txValidB), .txReady(txReadyB), .txData(txDataB), .txBusy(txBusyB), .txDone(txDoneB));

    uart_core #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) uDutC (
        .clk(clk), .rst(rst), .rx(rxC), .rxEn(rxEnC), .rxData(rxDataC), .rxValid(rxValidC),
        .rxBusy(rxBusyC), .rxParityErr(rxParC), .rxFrameErr(rxFrameC), .tx(txC), .txEn(txEnC),
        .txValid(txValidC), .txReady(txReadyC), .txData(txDataC), .txBusy(txBusyC), .txDone(txDoneC));

    int checkCnt = 0;
    int errCnt   = 0;
    int aValid   = 0;
    int cValid   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rxValidA === 1'b1) aValid++;
        if (rxValidC === 1'b1) cValid++;
    end

    // drives n line bits (bits[0] first), each BIT clocks; call on a falling edge
    task automatic driveBits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rxA = bits[i];
            else          rxC = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    // handshake one 8N1 word on instance A and check the whole frame cycle by cycle
    task automatic sendTxA(input logic [7:0] data, input string tag);
        int         okBits[10];
        int         doneAt;
        int         doneCnt;
        int         busyCnt;
        logic [9:0] frame;
        frame   = {1'b1, data, 1'b0};
        doneAt  = -1;
        doneCnt = 0;
        busyCnt = 0;
        for (int b = 0; b < 10; b++) okBits[b] = 0;
        check($sformatf("%s ready", tag), {31'd0, txReadyA}, 32'd1);
        txValidA = 1'b1;
        txDataA  = data;
        @(negedge clk);
        txValidA = 1'b0;
        txDataA  = ~data;
        for (int k = 1; k <= 160; k++) begin
            if (txA === frame[(k-1)/16]) okBits[(k-1)/16]++;
            if (txDoneA === 1'b1) begin
                doneCnt++;
                doneAt = k;
            end
            if (txBusyA === 1'b1) busyCnt++;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) check($sformatf("%s bit%0d", tag, b), okBits[b], 32'd16);
        check($sformatf("%s doneAt", tag), doneAt, 32'd160);
        check($sformatf("%s doneCnt", tag), doneCnt, 32'd1);
        check($sformatf("%s busyCnt", tag), busyCnt, 32'd160);
        check($sformatf("%s readyAfter", tag), {31'd0, txReadyA}, 32'd1);
        check($sformatf("%s idleTx", tag), {31'd0, txA}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checkCnt);
        $fatal(1);
    end

    initial begin
        int         rxN;
        int         gap;
        int         gapHigh;
        int         doneB;
        logic [7:0] gotD[2];
        logic       gotP[2];
        logic       gotF[2];
        logic       sawBusy;

        repeat (3) @(negedge clk);
        check("rst tx",      {31'd0, txA},      32'd1);
        check("rst txReady", {31'd0, txReadyA}, 32'd0);
        check("rst txBusy",  {31'd0, txBusyA},  32'd0);
        check("rst txDone",  {31'd0, txDoneA},  32'd0);
        check("rst rxValid", {31'd0, rxValidA}, 32'd0);
        check("rst rxBusy",  {31'd0, rxBusyA},  32'd0);
        check("rst rxData",  {24'd0, rxDataA},  32'd0);
        check("rst rxPar",   {31'd0, rxParA},   32'd0);
        check("rst rxFrame", {31'd0, rxFrameA}, 32'd0);
        check("rst txC",     {31'd0, txC},      32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: 8N1 transmit of 0xA5
        sendTxA(8'hA5, "t1");

        // 2: loopback even parity, 2 stop bits, back-to-back 0x5A then 0xFF
        rxN = 0; gap = 0; gapHigh = 0; doneB = 0;
        txValidB = 1'b1;
        txDataB  = 8'h5A;
        @(negedge clk);
        txDataB = 8'hFF;
        for (int k = 0; k < 420; k++) begin
            if (rxValidB === 1'b1 && rxN < 2) begin
                gotD[rxN] = rxDataB;
                gotP[rxN] = rxParB;
                gotF[rxN] = rxFrameB;
                rxN++;
            end
            if (txDoneB === 1'b1) doneB++;
            if (doneB == 1 && txBusyB === 1'b0) begin
                gap++;
                if (txB === 1'b1) gapHigh++;
            end
            if (doneB == 1 && txBusyB === 1'b1 && gap > 0) txValidB = 1'b0;
            @(negedge clk);
        end
        txValidB = 1'b0;
        check("t2 rxCount", rxN, 32'd2);
        check("t2 data0",   {24'd0, gotD[0]}, 32'h5A);
        check("t2 par0",    {31'd0, gotP[0]}, 32'd0);
        check("t2 frame0",  {31'd0, gotF[0]}, 32'd0);
        check("t2 data1",   {24'd0, gotD[1]}, 32'hFF);
        check("t2 par1",    {31'd0, gotP[1]}, 32'd0);
        check("t2 frame1",  {31'd0, gotF[1]}, 32'd0);
        check("t2 gap",     gap,     32'd1);
        check("t2 gapHigh", gapHigh, 32'd1);
        check("t2 doneCnt", doneB,   32'd2);

        // 3: odd parity receiver fed 0x3C with an even parity bit (0)
        driveBits(1, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11);
        rxC = 1'b1;
        repeat (20) @(negedge clk);
        check("t3 valid", cValid, 32'd1);
        check("t3 data",  {24'd0, rxDataC},  32'h3C);
        check("t3 par",   {31'd0, rxParC},   32'd1);
        check("t3 frame", {31'd0, rxFrameC}, 32'd0);

        // 4: framing error on 0x81, then a clean 0x42
        driveBits(0, 16'({1'b0, 8'h81, 1'b0}), 10);
        rxA = 1'b1;
        repeat (20) @(negedge clk);
        check("t4 valid1", aValid, 32'd1);
        check("t4 data1",  {24'd0, rxDataA},  32'h81);
        check("t4 frame1", {31'd0, rxFrameA}, 32'd1);
        check("t4 par1",   {31'd0, rxParA},   32'd0);
        driveBits(0, 16'({1'b1, 8'h42, 1'b0}), 10);
        rxA = 1'b1;
        repeat (20) @(negedge clk);
        check("t4 valid2", aValid, 32'd2);
        check("t4 data2",  {24'd0, rxDataA},  32'h42);
        check("t4 frame2", {31'd0, rxFrameA}, 32'd0);

        // 5a: 4-clock glitch is rejected
        rxA = 1'b0;
        repeat (4) @(negedge clk);
        rxA = 1'b1;
        sawBusy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (rxBusyA === 1'b1) sawBusy = 1'b1;
            @(negedge clk);
        end
        check("t5 glitchBusy",  {31'd0, sawBusy}, 32'd1);
        check("t5 glitchIdle",  {31'd0, rxBusyA}, 32'd0);
        check("t5 glitchValid", aValid, 32'd2);

        // 5b: rxEn dropped mid-DATA aborts the frame
        driveBits(0, 16'({1'b0, 1'b1, 1'b1, 1'b0}), 4);
        check("t5 midBusy", {31'd0, rxBusyA}, 32'd1);
        rxEnA = 1'b0;
        @(negedge clk);
        check("t5 abortIdle", {31'd0, rxBusyA}, 32'd0);
        rxA = 1'b1;
        repeat (20) @(negedge clk);
        rxEnA = 1'b1;
        repeat (5) @(negedge clk);
        check("t5 abortValid", aValid, 32'd2);
        check("t5 abortData",  {24'd0, rxDataA},  32'h42);
        check("t5 abortFrame", {31'd0, rxFrameA}, 32'd0);

        // 6: asynchronous reset during data bit 2 of 0x33 (a 0 on the line)
        txValidA = 1'b1;
        txDataA  = 8'h33;
        @(negedge clk);
        txValidA = 1'b0;
        repeat (54) @(negedge clk);
        check("t6 preTx",   {31'd0, txA},     32'd0);
        check("t6 preBusy", {31'd0, txBusyA}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6 rstTx",    {31'd0, txA},      32'd1);
        check("t6 rstBusy",  {31'd0, txBusyA},  32'd0);
        check("t6 rstReady", {31'd0, txReadyA}, 32'd0);
        check("t6 rstDone",  {31'd0, txDoneA},  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        sendTxA(8'h0F, "t6");

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
